// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the shift-and-add multiply sequencer.
// Exposes the FSM state encoding and the default operand width.
package mult_seq_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_sequencer.sv
// Unsigned shift-and-add multiplier sequencer.
// Borrows an external shared ripple adder through the add_* ports.
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clock,
  input  logic               n_reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   mult_a,
  input  logic [WIDTH-1:0]   mult_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_x,
  output logic [WIDTH-1:0]   add_y,
  output logic               add_cin,
  input  logic [WIDTH:0]     add_sum
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   reg_a_q, reg_a_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      reg_a_q   <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      reg_a_q   <= reg_a_d;
      acc_q     <= acc_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    reg_a_d   = reg_a_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          reg_a_d = mult_a;
          lo_d    = mult_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_x = acc_q;
        add_y = lo_q[0] ? reg_a_q : '0;
        // Carry-out lands in acc MSB; sum LSB shifts into lo MSB.
        acc_d = add_sum[WIDTH:1];
        lo_d  = {add_sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          product_d = {add_sum, lo_q[WIDTH-1:1]};
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == RUN) || (state_q == DONE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench: behavioural shared adder plus a product/latency model.
// Covers reset, exhaustive sweep, held start, mid-run perturbation and abort.
module tb_mult_sequencer;

  localparam int W = 4;

  logic           clock;
  logic           n_reset;
  logic           start;
  logic [W-1:0]   mult_a;
  logic [W-1:0]   mult_b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [W-1:0]   add_x;
  logic [W-1:0]   add_y;
  logic           add_cin;
  logic [W:0]     add_sum;

  int n_chk;
  int n_fail;
  int done_cnt;
  int cyc;
  int last_prod;

  mult_sequencer #(.WIDTH(W)) dut (
    .clock   (clock),
    .n_reset (n_reset),
    .start   (start),
    .mult_a  (mult_a),
    .mult_b  (mult_b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .add_x   (add_x),
    .add_y   (add_y),
    .add_cin (add_cin),
    .add_sum (add_sum)
  );

  assign add_sum = (W+1)'(add_x) + (W+1)'(add_y) + (W+1)'(add_cin);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_op(input int a, input int b,
                       input bit perturb, input bit y_zero);
    int k;
    @(negedge clock);
    n_reset = 1'b1;
    start   = 1'b1;
    mult_a  = W'(a);
    mult_b  = W'(b);
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_run", {31'b0, busy}, 1);
    check("prod_hold", {24'b0, product}, last_prod);
    k = 1;
    while (k <= W + 4 && done !== 1'b1) begin
      if (y_zero) check("add_y_zero", {28'b0, add_y}, 0);
      if (perturb) begin
        mult_a = W'($urandom);
        mult_b = W'($urandom);
        start  = 1'($urandom);
      end
      @(posedge clock); #1;
      k++;
    end
    start = 1'b0;
    check("latency", k, W + 1);
    check("product", {24'b0, product}, a * b);
    check("add_idle", {23'b0, add_x, add_y, add_cin}, 0);
    last_prod = a * b;
    @(posedge clock); #1;
    check("done_pulse", {30'b0, done, busy}, 0);
  endtask

  initial begin
    int d0;
    int q[$];
    n_chk = 0; n_fail = 0; done_cnt = 0; cyc = 0; last_prod = 0;
    n_reset = 1'b0; start = 1'b0; mult_a = '0; mult_b = '0;
    #12;
    check("rst_outs", {22'b0, busy, done, product}, 0);
    check("rst_add", {23'b0, add_x, add_y, add_cin}, 0);

    do_op(15, 15, 0, 0);
    do_op(9, 7, 0, 0);
    do_op(0, 13, 0, 1);

    d0 = done_cnt;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(a, b, 0, (a == 0) || (b == 0));
    check("sweep_dones", done_cnt - d0, 256);

    // Continuous start: one result every W+2 cycles.
    @(negedge clock);
    start = 1'b1; mult_a = 4'd3; mult_b = 4'd5;
    for (int i = 0; i < 30 && q.size() < 3; i++) begin
      @(posedge clock); #1;
      if (done === 1'b1) begin
        q.push_back(cyc);
        check("held_prod", {24'b0, product}, 15);
      end
    end
    start = 1'b0;
    check("held_count", q.size(), 3);
    if (q.size() == 3) begin
      check("held_gap1", q[1] - q[0], W + 2);
      check("held_gap2", q[2] - q[1], W + 2);
    end
    repeat (W + 3) @(posedge clock);
    last_prod = 15;

    // Operand change mid-run must not matter.
    @(negedge clock);
    start = 1'b1; mult_a = 4'd6; mult_b = 4'd6;
    @(posedge clock); #1;
    start = 1'b0; mult_a = 4'd1;
    for (int i = 0; i < W + 4 && done !== 1'b1; i++) begin
      @(posedge clock); #1;
    end
    check("midrun_prod", {24'b0, product}, 36);
    last_prod = 36;
    @(posedge clock); #1;

    for (int i = 0; i < 24; i++)
      do_op($urandom_range(0, 15), $urandom_range(0, 15), 1, 0);

    // Abort mid-run by reset.
    @(negedge clock);
    start = 1'b1; mult_a = 4'd12; mult_b = 4'd11;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    d0 = done_cnt;
    n_reset = 1'b0;
    #1;
    check("abort_outs", {22'b0, busy, done, product}, 0);
    check("abort_add", {23'b0, add_x, add_y, add_cin}, 0);
    last_prod = 0;
    repeat (W + 2) @(posedge clock);
    #1;
    check("abort_nodone", done_cnt - d0, 0);
    do_op(9, 7, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, operand width; SHALL equal the width of the shared ripple adder.
REQ-002 clock  input  1  rising-edge clock; single clock domain.
REQ-003 n_reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  multiply request; sampled only in IDLE.
REQ-005 mult_a  input  WIDTH  multiplicand, unsigned.
REQ-006 mult_b  input  WIDTH  multiplier, unsigned.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  2*WIDTH  registered result.
REQ-010 add_x  output  WIDTH  to shared adder X operand.
REQ-011 add_y  output  WIDTH  to shared adder Y operand.
REQ-012 add_cin  output  1  to shared adder carry-in; constant 0.
REQ-013 add_sum  input  WIDTH+1  from shared adder, {cout, sum}; combinational in add_x/add_y/add_cin within the same cycle.

Function
REQ-014 States SHALL be IDLE, RUN, DONE; a bit counter cnt runs 0..WIDTH-1.
REQ-015 IDLE: if start=1 at a rising edge, latch mult_a into reg_a, load mult_b into lo, clear acc, clear cnt, go to RUN; else stay.
REQ-016 RUN: add_x=acc; add_y=reg_a if lo[0]=1, else 0; add_cin=0.
REQ-017 RUN edge: {acc, lo} SHALL become {add_sum, lo[WIDTH-1:1]} (shift right one with the adder carry entering the MSB); cnt increments.
REQ-018 RUN with cnt=WIDTH-1: after the update, go to DONE; product SHALL load {acc, lo} as updated on that edge.
REQ-019 DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-020 Latency: start sampled on edge E0 -> done high during the cycle following edge E0+WIDTH (WIDTH RUN cycles then one DONE cycle).
REQ-021 start held high continuously SHALL give one operation per WIDTH+2 cycles (IDLE, WIDTH x RUN, DONE).
REQ-022 start, mult_a, mult_b SHALL be ignored in RUN and DONE; operand changes mid-operation do not affect the result.
REQ-023 product SHALL hold its value from DONE until the next DONE; it does not change on start acceptance.
REQ-024 In IDLE and DONE, add_x=0, add_y=0, add_cin=0.
REQ-025 Result arithmetic: product = mult_a * mult_b exactly, no truncation; max 15*15=225 at WIDTH=4.

Reset
REQ-026 n_reset=0 SHALL asynchronously force state IDLE, busy=0, done=0, product=0, acc=0, lo=0, reg_a=0, cnt=0, add_x/add_y/add_cin=0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after release is sampled on the first rising edge with n_reset=1.

Structure
REQ-028 Package mult_seq_pkg SHALL hold typedef state_t {IDLE, RUN, DONE} and the default WIDTH constant.
REQ-029 No sub-module; the adder is external and shared via add_x/add_y/add_cin/add_sum.

Verification
REQ-030 Bench SHALL wire a behavioural WIDTH-bit adder to the add_* ports.
REQ-031 mult_a=15, mult_b=15, start pulse -> done after 4 RUN cycles, product=225 (0xE1).
REQ-032 mult_a=9, mult_b=7 -> product=63; mult_a=0, mult_b=13 -> product=0, add_y=0 every RUN cycle.
REQ-033 Exhaustive 16x16 operand sweep -> every product equals a*b; done count = 256.
REQ-034 start held high with mult_a=3, mult_b=5 -> done pulses exactly 6 cycles apart, product=15 each time.
REQ-035 Change mult_a to 1 during RUN of 6*6 -> product=36; assert n_reset during RUN -> all outputs 0 immediately, no done pulse.
